// File: rtl/fft_uart_packer_if.sv
// Handshake bundle shared by the FFT result source, the packer and the UART transmitter.
interface fft_uart_packer_if;
    logic        i_data_valid;
    logic [15:0] i_data;
    logic        o_ready;
    logic        o_overflow;
    logic        o_tx_start;
    logic [7:0]  o_tx_byte;
    logic        i_tx_done;
    logic        o_frame_done;

    modport master (
        output i_data_valid, i_data, i_tx_done,
        input  o_ready, o_overflow, o_tx_start, o_tx_byte, o_frame_done
    );

    modport slave (
        input  i_data_valid, i_data, i_tx_done,
        output o_ready, o_overflow, o_tx_start, o_tx_byte, o_frame_done
    );
endinterface

// File: rtl/fft_uart_packer.sv
// Buffers one frame of 16-bit FFT words and streams it byte-by-byte to a UART (header, then hi/lo bytes).
// Optional macro PACKER_CHECKSUM_EN appends an XOR checksum of the data bytes.
module fft_uart_packer #(
    parameter int         N_WORDS  = 16,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input logic              i_clk,
    input logic              i_rst,
    fft_uart_packer_if.slave bus
);

`ifdef PACKER_CHECKSUM_EN
    localparam int FRAME_LEN = 2 * N_WORDS + 2;
`else
    localparam int FRAME_LEN = 2 * N_WORDS + 1;
`endif
    localparam int LAST_IDX = FRAME_LEN - 1;
    localparam int PTR_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int IDX_W    = $clog2(FRAME_LEN);

    typedef enum logic [2:0] {CAPTURE, ISSUE, WAIT, NEXT, FIN} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [IDX_W-1:0] byte_idx, byte_idx_nxt;
    logic             wr_en;
    logic [15:0]      buffer [N_WORDS];
    logic [PTR_W-1:0] word_sel;
    logic [7:0]       byte_sel;

    logic       ready_r, ready_nxt;
    logic       overflow_r, overflow_nxt;
    logic       start_r, start_nxt;
    logic       done_r, done_nxt;
    logic [7:0] tx_byte_r, tx_byte_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            byte_idx   <= '0;
            ready_r    <= 1'b1;
            overflow_r <= 1'b0;
            start_r    <= 1'b0;
            done_r     <= 1'b0;
            tx_byte_r  <= 8'h00;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            byte_idx   <= byte_idx_nxt;
            ready_r    <= ready_nxt;
            overflow_r <= overflow_nxt;
            start_r    <= start_nxt;
            done_r     <= done_nxt;
            tx_byte_r  <= tx_byte_nxt;
        end
    end

    // Outputs are registered from the next state, so each pulse lines up with the state it belongs to.
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        byte_idx_nxt = byte_idx;
        wr_en        = 1'b0;
        case (state)
            CAPTURE: begin
                if (bus.i_data_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == PTR_W'(N_WORDS - 1)) begin
                        wr_ptr_nxt   = '0;
                        byte_idx_nxt = '0;
                        state_nxt    = ISSUE;
                    end else begin
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                    end
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.i_tx_done) state_nxt = NEXT;
            NEXT: begin
                if (byte_idx == IDX_W'(LAST_IDX)) begin
                    state_nxt = FIN;
                end else begin
                    byte_idx_nxt = byte_idx + IDX_W'(1);
                    state_nxt    = ISSUE;
                end
            end
            FIN:     state_nxt = CAPTURE;
            default: state_nxt = CAPTURE;
        endcase
        ready_nxt    = (state_nxt == CAPTURE);
        overflow_nxt = bus.i_data_valid && !ready_r;
        start_nxt    = (state_nxt == ISSUE);
        done_nxt     = (state_nxt == FIN);
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) buffer[wr_ptr] <= bus.i_data;
    end

`ifdef PACKER_CHECKSUM_EN
    logic [7:0] chk;

    // Running XOR restarts on word 0, so an aborted frame never leaks into the next one.
    always_ff @(posedge i_clk) begin
        if (wr_en) chk <= ((wr_ptr == '0) ? 8'h00 : chk) ^ bus.i_data[15:8] ^ bus.i_data[7:0];
    end
`endif

    // Odd frame indices carry the high byte of word (idx-1)/2, even ones the low byte.
    always_comb begin
        word_sel = PTR_W'((byte_idx_nxt - IDX_W'(1)) >> 1);
        byte_sel = byte_idx_nxt[0] ? buffer[word_sel][15:8] : buffer[word_sel][7:0];
        if (byte_idx_nxt == '0) byte_sel = HDR_BYTE;
`ifdef PACKER_CHECKSUM_EN
        else if (byte_idx_nxt == IDX_W'(LAST_IDX)) byte_sel = chk;
`endif
        tx_byte_nxt = start_nxt ? byte_sel : tx_byte_r;
    end

    assign bus.o_ready      = ready_r;
    assign bus.o_overflow   = overflow_r;
    assign bus.o_tx_start   = start_r;
    assign bus.o_tx_byte    = tx_byte_r;
    assign bus.o_frame_done = done_r;

endmodule
